// File: rtl/full_st0_input_framer_pkg.sv
// Shared types for the stage-0 input framer: sample payload type and FSM encoding.
package full_st0_input_framer_pkg;

    typedef logic [31:0] float_24_8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } framer_state_e;

endpackage

// File: rtl/full_st0_skid_buffer.sv
// Two-entry ready/valid buffer; entry 0 is always the head so the output is a plain register.
module full_st0_skid_buffer #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_e0;
    logic [W-1:0] r_e1;
    logic [1:0]   r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e0    <= '0;
            r_e1    <= '0;
            r_count <= '0;
        end else begin
            // Caller never pushes when full, so push+pop only happens at count 1.
            if (i_pop) begin
                if (r_count == 2'd2)
                    r_e0 <= r_e1;
                else if (i_push)
                    r_e0 <= i_data;
            end else if (i_push) begin
                if (r_count == 2'd0)
                    r_e0 <= i_data;
                else
                    r_e1 <= i_data;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_head  = r_e0;
    assign o_count = r_count;

endmodule

// File: rtl/full_st0_input_framer.sv
// Cuts the raw sample stream into bursts of load_length+1 words, tags the first word,
// pads partial bursts on disable and feeds stage_0_data through a 2-entry skid buffer.
//
// state | meaning
// IDLE  | not framing; buffered words still drain
// RUN   | accepting samples into the buffer
// FLUSH | writing zero pad words until the burst is complete
module full_st0_input_framer
    import full_st0_input_framer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int LEN_WIDTH   = 3,
    parameter int DEPTH_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_enable,
    input  logic [LEN_WIDTH-1:0]   load_length,
    input  logic [DEPTH_WIDTH-1:0] load_depth,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_vld,
    input  logic                   in_last,
    output logic                   in_rdy,
    output logic [DATA_WIDTH-1:0]  stage_0_data,
    output logic                   stage_0_data_fst,
    output logic                   stage_0_data_vld,
    input  logic                   stage_0_data_rdy,
    output logic                   burst_done,
    output logic                   block_done,
    output logic [DEPTH_WIDTH-1:0] burst_index,
    output logic                   len_err
);

    localparam logic [LEN_WIDTH-1:0]   IDX_ONE = 1;
    localparam logic [DEPTH_WIDTH-1:0] BUR_ONE = 1;

    framer_state_e          r_state, w_state_nxt;
    logic [LEN_WIDTH-1:0]   r_word_idx, w_idx_nxt;
    logic [LEN_WIDTH-1:0]   r_len_lat;
    logic [DEPTH_WIDTH-1:0] r_dep_lat;
    logic [DEPTH_WIDTH-1:0] r_burst_index;
    logic                   r_len_err, r_burst_done, r_block_done;

    logic [1:0]             w_count;
    logic [DATA_WIDTH:0]    w_head;
    logic [DATA_WIDTH-1:0]  w_wr_data;
    logic w_pop, w_wr_run, w_wr_pad, w_wr, w_at_end, w_early, w_burst_end;

    assign in_rdy           = (r_state == ST_RUN) && (w_count < 2'd2);
    assign stage_0_data_vld = (w_count != 2'd0);
    assign w_pop            = stage_0_data_vld && stage_0_data_rdy;

    assign w_wr_run    = (r_state == ST_RUN) && in_vld && in_rdy;
    assign w_wr_pad    = (r_state == ST_FLUSH) && (w_count < 2'd2);
    assign w_wr        = w_wr_run || w_wr_pad;
    assign w_at_end    = (r_word_idx == r_len_lat);
    assign w_early     = w_wr_run && in_last && !w_at_end;
    assign w_burst_end = w_wr && w_at_end;
    assign w_wr_data   = w_wr_pad ? '0 : in_data;

    full_st0_skid_buffer #(.W(DATA_WIDTH + 1)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_wr),
        .i_data  ({(r_word_idx == '0), w_wr_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign {stage_0_data_fst, stage_0_data} = w_head;

    always_comb begin
        w_idx_nxt = r_word_idx;
        if (w_wr)
            w_idx_nxt = (w_at_end || w_early) ? '0 : r_word_idx + IDX_ONE;
    end

    // Disable decision uses the post-write index so a word accepted on the
    // disabling edge still gets its burst padded out.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (cfg_enable) w_state_nxt = ST_RUN;
            ST_RUN:   if (!cfg_enable) w_state_nxt = (w_idx_nxt == '0) ? ST_IDLE : ST_FLUSH;
            ST_FLUSH: if (w_burst_end) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_word_idx    <= '0;
            r_len_lat     <= '0;
            r_dep_lat     <= '0;
            r_burst_index <= '0;
            r_len_err     <= 1'b0;
            r_burst_done  <= 1'b0;
            r_block_done  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_word_idx <= w_idx_nxt;
            if (r_state == ST_IDLE && cfg_enable) begin
                r_len_lat <= load_length;
                r_dep_lat <= load_depth;
                r_len_err <= 1'b0;
            end else if (w_early) begin
                r_len_err <= 1'b1;
            end
            r_burst_done <= w_burst_end;
            r_block_done <= w_burst_end && (r_burst_index == r_dep_lat);
            if (w_burst_end)
                r_burst_index <= (r_burst_index == r_dep_lat) ? '0 : r_burst_index + BUR_ONE;
        end
    end

    assign burst_done  = r_burst_done;
    assign block_done  = r_block_done;
    assign burst_index = r_burst_index;
    assign len_err     = r_len_err;

endmodule

// File: tb/tb_full_st0_input_framer.sv
// Directed bench for the stage-0 input framer with hand-computed expectations.
module tb_full_st0_input_framer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_enable;
    logic [2:0]  load_length;
    logic [2:0]  load_depth;
    logic [31:0] in_data;
    logic        in_vld;
    logic        in_last;
    logic        in_rdy;
    logic [31:0] stage_0_data;
    logic        stage_0_data_fst;
    logic        stage_0_data_vld;
    logic        stage_0_data_rdy;
    logic        burst_done;
    logic        block_done;
    logic [2:0]  burst_index;
    logic        len_err;

    int n_vec = 0;
    int n_err = 0;

    full_st0_input_framer #(.DATA_WIDTH(32), .LEN_WIDTH(3), .DEPTH_WIDTH(3)) dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_enable       (cfg_enable),
        .load_length      (load_length),
        .load_depth       (load_depth),
        .in_data          (in_data),
        .in_vld           (in_vld),
        .in_last          (in_last),
        .in_rdy           (in_rdy),
        .stage_0_data     (stage_0_data),
        .stage_0_data_fst (stage_0_data_fst),
        .stage_0_data_vld (stage_0_data_vld),
        .stage_0_data_rdy (stage_0_data_rdy),
        .burst_done       (burst_done),
        .block_done       (block_done),
        .burst_index      (burst_index),
        .len_err          (len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        in_vld  = 1'b1;
        in_data = d;
        in_last = last;
        cyc();
    endtask

    initial begin
        reset = 1'b0; cfg_enable = 1'b0; load_length = 3'd0; load_depth = 3'd0;
        in_data = '0; in_vld = 1'b0; in_last = 1'b0; stage_0_data_rdy = 1'b0;
        repeat (2) cyc();
        chk("rst_vld", stage_0_data_vld, 0);
        chk("rst_rdy", in_rdy, 0);
        chk("rst_bidx", burst_index, 0);
        chk("rst_err", len_err, 0);
        chk("rst_bdone", burst_done, 0);
        chk("rst_kdone", block_done, 0);
        reset = 1'b1;

        // back-to-back bursts, len=3 depth=1
        load_length = 3'd3; load_depth = 3'd1; cfg_enable = 1'b1; stage_0_data_rdy = 1'b1;
        cyc();
        chk("run_rdy", in_rdy, 1);
        for (int k = 1; k <= 8; k++) begin
            send(k, 1'b0);
            chk("bb_data", stage_0_data, k);
            chk("bb_vld", stage_0_data_vld, 1);
            chk("bb_fst", stage_0_data_fst, (k == 1 || k == 5));
            chk("bb_bdone", burst_done, (k == 4 || k == 8));
            chk("bb_kdone", block_done, (k == 8));
            chk("bb_bidx", burst_index, (k >= 4 && k < 8) ? 1 : 0);
            chk("bb_rdy", in_rdy, 1);
        end
        in_vld = 1'b0;
        cyc();
        chk("bb_drain", stage_0_data_vld, 0);

        // downstream stall for 5 cycles
        stage_0_data_rdy = 1'b0;
        send(11, 1'b0);
        chk("st_d11", stage_0_data, 11);
        chk("st_fst11", stage_0_data_fst, 1);
        chk("st_rdy1", in_rdy, 1);
        send(12, 1'b0);
        chk("st_hold", stage_0_data, 11);
        chk("st_full", in_rdy, 0);
        in_data = 13;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("st_hold", stage_0_data, 11);
            chk("st_hfst", stage_0_data_fst, 1);
            chk("st_vld", stage_0_data_vld, 1);
            chk("st_full", in_rdy, 0);
        end
        stage_0_data_rdy = 1'b1;
        cyc();
        chk("st_d12", stage_0_data, 12);
        chk("st_fst12", stage_0_data_fst, 0);
        chk("st_rdy2", in_rdy, 1);
        cyc();
        chk("st_d13", stage_0_data, 13);
        send(14, 1'b0);
        chk("st_d14", stage_0_data, 14);
        chk("st_bdone", burst_done, 1);
        chk("st_bidx", burst_index, 1);
        in_vld = 1'b0;
        cyc();
        chk("st_drain", stage_0_data_vld, 0);

        // early in_last
        cfg_enable = 1'b0;
        cyc();
        cfg_enable = 1'b1;
        cyc();
        send(21, 1'b0);
        send(22, 1'b1);
        chk("el_err", len_err, 1);
        chk("el_bidx", burst_index, 1);
        chk("el_bdone", burst_done, 0);
        send(23, 1'b0);
        chk("el_fst23", stage_0_data_fst, 1);
        chk("el_d23", stage_0_data, 23);
        send(24, 1'b0);
        send(25, 1'b0);
        send(26, 1'b0);
        chk("el_bdone26", burst_done, 1);
        chk("el_kdone26", block_done, 1);
        chk("el_bidx26", burst_index, 0);
        chk("el_err_keep", len_err, 1);
        in_vld = 1'b0; in_last = 1'b0;
        cfg_enable = 1'b0;
        cyc();
        chk("el_err_idle", len_err, 1);
        chk("el_idle_rdy", in_rdy, 0);
        cfg_enable = 1'b1;
        cyc();
        chk("el_err_clr", len_err, 0);
        chk("el_rerun", in_rdy, 1);

        // partial burst flushed with pad words
        send(31, 1'b0);
        send(32, 1'b0);
        chk("fl_d32", stage_0_data, 32);
        in_vld = 1'b0; cfg_enable = 1'b0;
        cyc();
        chk("fl_vld_a", stage_0_data_vld, 0);
        chk("fl_rdy_a", in_rdy, 0);
        cyc();
        chk("fl_vld_b", stage_0_data_vld, 1);
        chk("fl_pad_b", stage_0_data, 0);
        chk("fl_fst_b", stage_0_data_fst, 0);
        chk("fl_bd_b", burst_done, 0);
        cyc();
        chk("fl_vld_c", stage_0_data_vld, 1);
        chk("fl_pad_c", stage_0_data, 0);
        chk("fl_fst_c", stage_0_data_fst, 0);
        chk("fl_bd_c", burst_done, 1);
        chk("fl_bidx_c", burst_index, 1);
        cyc();
        chk("fl_vld_d", stage_0_data_vld, 0);
        chk("fl_rdy_d", in_rdy, 0);
        chk("fl_bd_d", burst_done, 0);

        // load_length change during RUN is ignored
        load_length = 3'd3; cfg_enable = 1'b1;
        cyc();
        load_length = 3'd7;
        send(41, 1'b0);
        send(42, 1'b0);
        send(43, 1'b0);
        send(44, 1'b0);
        chk("ll_bdone", burst_done, 1);
        send(45, 1'b0);
        chk("ll_fst45", stage_0_data_fst, 1);
        chk("ll_bd45", burst_done, 0);

        // reset mid-burst with two words buffered
        stage_0_data_rdy = 1'b0;
        send(46, 1'b0);
        send(47, 1'b0);
        chk("rs_full", in_rdy, 0);
        in_vld = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rs_vld", stage_0_data_vld, 0);
        chk("rs_rdy", in_rdy, 0);
        chk("rs_bidx", burst_index, 0);
        #1;
        reset = 1'b1;
        stage_0_data_rdy = 1'b1;
        cyc();
        send(51, 1'b0);
        chk("rs_d51", stage_0_data, 51);
        chk("rs_fst51", stage_0_data_fst, 1);
        in_vld = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
